// File: rtl/mips_alu_pkg.sv
// Shared types for the MIPS ALU: 32-bit word and the 6-bit ALUControl encoding.
package mips_alu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [5:0] {
    OP_SLL   = 6'h00,
    OP_SRL   = 6'h02,
    OP_SRA   = 6'h03,
    OP_SLLV  = 6'h04,
    OP_SRLV  = 6'h06,
    OP_SRAV  = 6'h07,
    OP_BEQ   = 6'h08,
    OP_BNE   = 6'h09,
    OP_BLEZ  = 6'h0A,
    OP_BGTZ  = 6'h0B,
    OP_BLTZ  = 6'h0C,
    OP_BGEZ  = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_MFHI  = 6'h10,
    OP_MTHI  = 6'h11,
    OP_MFLO  = 6'h12,
    OP_MTLO  = 6'h13,
    OP_MULT  = 6'h18,
    OP_MULTU = 6'h19,
    OP_DIV   = 6'h1A,
    OP_DIVU  = 6'h1B,
    OP_ADD   = 6'h20,
    OP_ADDU  = 6'h21,
    OP_SUB   = 6'h22,
    OP_SUBU  = 6'h23,
    OP_AND   = 6'h24,
    OP_OR    = 6'h25,
    OP_XOR   = 6'h26,
    OP_NOR   = 6'h27,
    OP_SLT   = 6'h2A,
    OP_SLTU  = 6'h2B
  } alu_op_e;

endpackage

// File: rtl/mips_alu_muldiv.sv
// HI/LO register pair with multiply, divide and move-to-HI/LO writes.
// Only instantiated when MIPS_ALU_MULDIV_EN is defined.
module mips_alu_muldiv
  import mips_alu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  alu_op_e op,
  input  word_t   a,
  input  word_t   b,
  output word_t   hi,
  output word_t   lo
);

  logic [63:0] prod_s, prod_u;
  logic        sgn_div, neg_q, neg_r;
  word_t       a_mag, b_mag, uq, ur, quot, rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 falls out naturally
  // (magnitude 0x80000000 re-negates to itself) with no special case.
  assign sgn_div = (op == OP_DIV);
  assign a_mag   = (sgn_div && a[31]) ? word_t'(-a) : a;
  assign b_mag   = (sgn_div && b[31]) ? word_t'(-b) : b;
  assign uq      = (b_mag != '0) ? a_mag / b_mag : '0;
  assign ur      = (b_mag != '0) ? a_mag % b_mag : '0;
  assign neg_q   = sgn_div && (a[31] ^ b[31]);
  assign neg_r   = sgn_div && a[31];
  assign quot    = neg_q ? word_t'(-uq) : uq;
  assign rem     = neg_r ? word_t'(-ur) : ur;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (op)
        OP_MULT:  {hi, lo} <= prod_s;
        OP_MULTU: {hi, lo} <= prod_u;
        OP_DIV, OP_DIVU: begin
          if (b != '0) begin
            hi <= rem;
            lo <= quot;
          end
        end
        OP_MTHI:  hi <= a;
        OP_MTLO:  lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_alu.sv
// Combinational MIPS ALU with branch compare. Define MIPS_ALU_MULDIV_EN to
// build in the HI/LO multiply/divide unit; otherwise those codes read as undefined.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ALUControl,
  input  logic [31:0] alu_src_1,
  input  logic [31:0] alu_src_2,
  output logic [31:0] alu_result,
  output logic        branch
);

  alu_op_e    op;
  logic [4:0] shamt;
  word_t      a, b;

  assign op    = alu_op_e'(ALUControl);
  assign a     = alu_src_1;
  assign b     = alu_src_2;
  assign shamt = a[4:0];

`ifdef MIPS_ALU_MULDIV_EN
  word_t hi, lo;

  mips_alu_muldiv u_muldiv (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo)
  );
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
`endif

  always_comb begin
    alu_result = '0;
    case (op)
      OP_SLL, OP_SLLV: alu_result = b << shamt;
      OP_SRL, OP_SRLV: alu_result = b >> shamt;
      OP_SRA, OP_SRAV: alu_result = word_t'($signed(b) >>> shamt);
      OP_ADD, OP_ADDU: alu_result = a + b;
      OP_SUB, OP_SUBU: alu_result = a - b;
      OP_AND:          alu_result = a & b;
      OP_OR:           alu_result = a | b;
      OP_XOR:          alu_result = a ^ b;
      OP_NOR:          alu_result = ~(a | b);
      OP_SLT:          alu_result = {31'h0, $signed(a) < $signed(b)};
      OP_SLTU:         alu_result = {31'h0, a < b};
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ:
                       alu_result = a + b;
      OP_LUI:          alu_result = {b[15:0], 16'h0000};
`ifdef MIPS_ALU_MULDIV_EN
      OP_MFHI:         alu_result = hi;
      OP_MFLO:         alu_result = lo;
`endif
      default: ;
    endcase
  end

  // Zero-compare branches look only at A's sign bit and zero-ness.
  always_comb begin
    branch = 1'b0;
    case (op)
      OP_BEQ:  branch = (a == b);
      OP_BNE:  branch = (a != b);
      OP_BLEZ: branch = a[31] || (a == '0);
      OP_BGTZ: branch = !a[31] && (a != '0);
      OP_BLTZ: branch = a[31];
      OP_BGEZ: branch = !a[31];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases plus randomized ops
// against a plain-arithmetic reference model of ALU results and HI/LO.
module tb_mips_alu;

`ifdef MIPS_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  ALUControl = '0;
  logic [31:0] alu_src_1 = '0;
  logic [31:0] alu_src_2 = '0;
  logic [31:0] alu_result;
  logic        branch;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mips_alu dut (
    .clk        (clk),
    .reset      (reset),
    .ALUControl (ALUControl),
    .alu_src_1  (alu_src_1),
    .alu_src_2  (alu_src_2),
    .alu_result (alu_result),
    .branch     (branch)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_result(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    int     sh = int'(a[4:0]);
    longint t;
    case (op)
      6'h00, 6'h04: return b << sh;
      6'h02, 6'h06: return b >> sh;
      6'h03, 6'h07: begin
        t = sb >>> sh;
        return t[31:0];
      end
      6'h20, 6'h21, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
        t = ua + ub;
        return t[31:0];
      end
      6'h22, 6'h23: begin
        t = ua - ub;
        return t[31:0];
      end
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (ua < ub) ? 32'd1 : 32'd0;
      6'h0F: return {b[15:0], 16'h0000};
      6'h10: return MD ? m_hi : 32'd0;
      6'h12: return MD ? m_lo : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_branch(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    case (op)
      6'h08: return a == b;
      6'h09: return a != b;
      6'h0A: return sa <= 0;
      6'h0B: return sa > 0;
      6'h0C: return sa < 0;
      6'h0D: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clk(logic rst, logic [5:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q, r;
    logic [63:0] p;
    if (rst) begin
      m_hi = '0;
      m_lo = '0;
    end else if (MD) begin
      case (op)
        6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h19: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h1A: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        6'h1B: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        6'h11: m_hi = a;
        6'h13: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Drive one op across a rising edge; outputs then reflect the new HI/LO.
  task automatic clk_op(logic rst, logic [5:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    reset = rst; ALUControl = op; alu_src_1 = a; alu_src_2 = b;
    @(posedge clk);
    model_clk(rst, op, a, b);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clk_op(1'b0, 6'h11, 32'hDEAD_BEEF, 32'h0);
    clk_op(1'b1, 6'h13, 32'h1234_5678, 32'h0);
    @(negedge clk); ALUControl = 6'h10; #1;
    tests++;
    if (alu_result !== 32'h0) begin
      fails++; $display("FAIL reset_hi got=%h exp=%h", alu_result, 32'h0);
    end
    ALUControl = 6'h12; #1;
    tests++;
    if (alu_result !== 32'h0) begin
      fails++; $display("FAIL reset_lo got=%h exp=%h", alu_result, 32'h0);
    end
  endtask

  task automatic test_directed();
    logic [5:0]  ops [10] = '{6'h21, 6'h23, 6'h03, 6'h04, 6'h2A, 6'h2B, 6'h0D, 6'h0C, 6'h09, 6'h0F};
    logic [31:0] as  [10] = '{32'hFFFF_FFFF, 32'h0, 32'h4, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h0, 32'h0, 32'h5, 32'h0};
    logic [31:0] bs  [10] = '{32'h1, 32'h1, 32'h8000_0000, 32'h1, 32'h1, 32'h1, 32'h7, 32'h7, 32'h5,
                              32'hABCD_1234};
    logic [31:0] rs  [10] = '{32'h0, 32'hFFFF_FFFF, 32'hF800_0000, 32'h2, 32'h1, 32'h0, 32'h7, 32'h7,
                              32'hA, 32'h1234_0000};
    logic        brs [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ALUControl = ops[i]; alu_src_1 = as[i]; alu_src_2 = bs[i];
      #1;
      tests++;
      if (alu_result !== rs[i]) begin
        fails++; $display("FAIL directed_result op=%h got=%h exp=%h", ops[i], alu_result, rs[i]);
      end
      tests++;
      if (branch !== brs[i]) begin
        fails++; $display("FAIL directed_branch op=%h got=%b exp=%b", ops[i], branch, brs[i]);
      end
    end
  endtask

  task automatic test_hilo();
    logic [31:0] exp_hi [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] exp_lo [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [5:0]  wops   [4] = '{6'h18, 6'h1A, 6'h1B, 6'h1A};
    logic [31:0] was    [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000};
    logic [31:0] wbs    [4] = '{32'h3, 32'h2, 32'h0, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      clk_op(1'b0, wops[i], was[i], wbs[i]);
      @(negedge clk); ALUControl = 6'h10; #1;
      tests++;
      if (alu_result !== (MD ? exp_hi[i] : 32'h0)) begin
        fails++; $display("FAIL hilo_hi step=%0d got=%h exp=%h", i, alu_result, MD ? exp_hi[i] : 32'h0);
      end
      ALUControl = 6'h12; #1;
      tests++;
      if (alu_result !== (MD ? exp_lo[i] : 32'h0)) begin
        fails++; $display("FAIL hilo_lo step=%0d got=%h exp=%h", i, alu_result, MD ? exp_lo[i] : 32'h0);
      end
    end
    clk_op(1'b0, 6'h1A, 32'h5, 32'h0);
    clk_op(1'b1, 6'h18, 32'h7, 32'h9);
    @(negedge clk); ALUControl = 6'h10; #1;
    tests++;
    if (alu_result !== 32'h0) begin
      fails++; $display("FAIL hilo_reset_hi got=%h exp=%h", alu_result, 32'h0);
    end
    ALUControl = 6'h12; #1;
    tests++;
    if (alu_result !== 32'h0) begin
      fails++; $display("FAIL hilo_reset_lo got=%h exp=%h", alu_result, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    for (int i = 0; i < 20; i++) begin
      x = $urandom; y = $urandom;
      clk_op(1'b0, 6'h11, x, 32'h0);
      clk_op(1'b0, 6'h13, y, 32'h0);
      clk_op(1'b0, 6'h19, x, y);
      @(negedge clk); ALUControl = (i % 2 == 0) ? 6'h10 : 6'h12; #1;
      tests++;
      if (alu_result !== model_result(ALUControl, 32'h0, 32'h0)) begin
        fails++; $display("FAIL b2b_read op=%h got=%h exp=%h", ALUControl, alu_result,
                          model_result(ALUControl, 32'h0, 32'h0));
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [37] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13,
                              6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                              6'h0F, 6'h01, 6'h0E, 6'h14, 6'h1F, 6'h30, 6'h3F};
    logic [5:0]  op;
    logic [31:0] a, b, er;
    logic        eb, rst;
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 36)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = 32'h0;
        2: a = 32'h0;
        3: a = 32'($urandom_range(0, 40));
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      reset = rst; ALUControl = op; alu_src_1 = a; alu_src_2 = b;
      #1;
      er = model_result(op, a, b);
      eb = model_branch(op, a, b);
      tests++;
      if (alu_result !== er) begin
        fails++; $display("FAIL rand_result op=%h a=%h b=%h got=%h exp=%h", op, a, b, alu_result, er);
      end
      tests++;
      if (branch !== eb) begin
        fails++; $display("FAIL rand_branch op=%h a=%h b=%h got=%b exp=%b", op, a, b, branch, eb);
      end
      @(posedge clk);
      model_clk(rst, op, a, b);
      #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hilo();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
